// File: rtl/sample_frame_streamer.sv
// sample_frame_streamer: snapshots a SAMPLES-deep window of WIDTH-bit samples
// and replays it one word per valid/ready handshake, oldest sample first.
// A load on the final handshake starts the next frame with no gap.
// Any other load while a frame is held is dropped and flagged on overrun.
module sample_frame_streamer #(
    parameter int SAMPLES = 16,
    parameter int WIDTH   = 32
) (
    input  logic                       adc_clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           frame_in [SAMPLES-1:0],
    input  logic                       load,
    output logic                       busy,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_first,
    output logic                       out_last,
    output logic [$clog2(SAMPLES)-1:0] out_index,
    output logic                       overrun,
    input  logic                       clear_overrun
);

    localparam int IDX_W = $clog2(SAMPLES);
    localparam logic [IDX_W-1:0] OLDEST_IDX = IDX_W'(SAMPLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic             capture;
    logic             handshake;
    logic             reject;
    logic [WIDTH-1:0] frame_reg [SAMPLES-1:0];

    // Next-state, index and overrun decisions for the readout FSM.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case leaves one unassigned and no latch can be inferred.
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        handshake = 1'b0;
        reject    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    idx_d   = OLDEST_IDX;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                handshake = out_ready;
                if (handshake && idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (handshake) begin
                    // Final word leaves this cycle: chain straight into a new
                    // frame when one is offered, otherwise go quiet.
                    if (load) begin
                        capture = 1'b1;
                        idx_d   = OLDEST_IDX;
                    end else begin
                        state_d = IDLE;
                    end
                end
                reject = load && !capture;
            end
            default: state_d = IDLE;
        endcase

        // A rejected load wins over a clear arriving in the same cycle.
        if (reject) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // FSM state, read index and sticky overrun flag.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from the values present before the edge.
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot register: loaded only on the accepting edge.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is deliberately reset so a discarded frame can
            // never reappear on out_data; it is flops, not an inferred RAM.
            for (int i = 0; i < SAMPLES; i++) begin
                frame_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < SAMPLES; i++) begin
                frame_reg[i] <= frame_in[i];
            end
        end
    end

    // Outputs decode registered state only; load and out_ready never reach them.
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_data  = (state_q == STREAM) ? frame_reg[idx_q] : '0;
    assign out_index = idx_q;
    assign out_first = (state_q == STREAM) && (idx_q == OLDEST_IDX);
    assign out_last  = (state_q == STREAM) && (idx_q == '0);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_frame_streamer.sv
// Bench for sample_frame_streamer at SAMPLES=4, WIDTH=8: a directed vector
// table, hand-written corner sequences, then random traffic against a
// queue-based reference model.
module tb_sample_frame_streamer;

    localparam int SAMPLES = 4;
    localparam int WIDTH   = 8;

    logic             adc_clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] frame_in [SAMPLES-1:0];
    logic             load;
    logic             busy;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_first;
    logic             out_last;
    logic [1:0]       out_index;
    logic             overrun;
    logic             clear_overrun;

    int checks = 0;
    int errors = 0;

    sample_frame_streamer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
        .adc_clk       (adc_clk),
        .rst_n         (rst_n),
        .frame_in      (frame_in),
        .load          (load),
        .busy          (busy),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_first     (out_first),
        .out_last      (out_last),
        .out_index     (out_index),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic       load;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [7:0] d;
        logic [1:0] i;
        logic       f;
        logic       l;
        logic       b;
        logic       o;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         idx;
    } word_t;

    vec_t  tbl [9];
    word_t model_q [$];
    logic  model_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] i, input logic f, input logic l,
                             input logic b, input logic o);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".index"}, 32'(out_index), 32'(i));
        check({tag, ".first"}, 32'(out_first), 32'(f));
        check({tag, ".last"},  32'(out_last),  32'(l));
        check({tag, ".busy"},  32'(busy),      32'(b));
        check({tag, ".ovr"},   32'(overrun),   32'(o));
    endtask

    task automatic set_frame(input logic [7:0] w3, input logic [7:0] w2,
                             input logic [7:0] w1, input logic [7:0] w0);
        frame_in[3] = w3;
        frame_in[2] = w2;
        frame_in[1] = w1;
        frame_in[0] = w0;
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic l, input logic r, input logic c);
        load          = l;
        out_ready     = r;
        clear_overrun = c;
        @(posedge adc_clk);
        #1;
    endtask

    // Reference model: the held frame is a queue of words still to be sent.
    task automatic model_step(input logic l, input logic r, input logic c);
        bit hs, last_hs, rej;
        hs      = (model_q.size() > 0) && r;
        last_hs = hs && (model_q[0].idx == 0);
        rej     = l && (model_q.size() > 0) && !last_hs;
        if (hs) void'(model_q.pop_front());
        if (l && model_q.size() == 0) begin
            for (int k = SAMPLES - 1; k >= 0; k--) begin
                word_t w;
                w.data = frame_in[k];
                w.idx  = k;
                model_q.push_back(w);
            end
        end
        if (rej) model_ov = 1'b1;
        else if (c) model_ov = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        out_ready = 1'b0;
        clear_overrun = 1'b0;
        set_frame(8'hA3, 8'hB2, 8'hC1, 8'hD0);
        repeat (2) @(posedge adc_clk);
        #1;
        check_all("reset", 0, 8'h00, 2'd0, 0, 0, 0, 0);
        @(negedge adc_clk);
        rst_n = 1'b1;
        @(posedge adc_clk);
        #1;

        // Basic readout, overrun at index 2, 3-cycle backpressure on 0xB2, clear.
        tbl[0] = '{1, 1, 0, 1, 8'hA3, 2'd3, 1, 0, 1, 0};
        tbl[1] = '{0, 1, 0, 1, 8'hB2, 2'd2, 0, 0, 1, 0};
        tbl[2] = '{1, 0, 0, 1, 8'hB2, 2'd2, 0, 0, 1, 1};
        tbl[3] = '{0, 0, 0, 1, 8'hB2, 2'd2, 0, 0, 1, 1};
        tbl[4] = '{0, 0, 0, 1, 8'hB2, 2'd2, 0, 0, 1, 1};
        tbl[5] = '{0, 1, 0, 1, 8'hC1, 2'd1, 0, 0, 1, 1};
        tbl[6] = '{0, 1, 0, 1, 8'hD0, 2'd0, 0, 1, 1, 1};
        tbl[7] = '{0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0, 1};
        tbl[8] = '{0, 0, 1, 0, 8'h00, 2'd0, 0, 0, 0, 0};
        for (int n = 0; n < 9; n++) begin
            drive(tbl[n].load, tbl[n].rdy, tbl[n].clr);
            if (n == 0) set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
            check_all($sformatf("tbl%0d", n), tbl[n].v, tbl[n].d, tbl[n].i,
                      tbl[n].f, tbl[n].l, tbl[n].b, tbl[n].o);
        end

        // Back-to-back frames: load on the 0xD0 handshake, no bubble.
        set_frame(8'hA3, 8'hB2, 8'hC1, 8'hD0);
        drive(1, 1, 0);
        check_all("b2b.a3", 1, 8'hA3, 2'd3, 1, 0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        check_all("b2b.d0", 1, 8'hD0, 2'd0, 0, 1, 1, 0);
        set_frame(8'h13, 8'h12, 8'h11, 8'h10);
        drive(1, 1, 0);
        check_all("b2b.13", 1, 8'h13, 2'd3, 1, 0, 1, 0);
        drive(0, 1, 0);
        check_all("b2b.12", 1, 8'h12, 2'd2, 0, 0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        check_all("b2b.10", 1, 8'h10, 2'd0, 0, 1, 1, 0);
        drive(0, 1, 0);
        check_all("b2b.idle", 0, 8'h00, 2'd0, 0, 0, 0, 0);

        // Load with clear in the same STREAM cycle: set wins.
        drive(1, 0, 0);
        drive(1, 0, 1);
        check_all("setclr", 1, 8'h13, 2'd3, 1, 0, 1, 1);
        drive(0, 0, 1);
        check_all("clr", 1, 8'h13, 2'd3, 1, 0, 1, 0);

        // Asynchronous reset at index 1, between clock edges.
        drive(0, 1, 0);
        drive(0, 1, 0);
        check_all("pre_rst", 1, 8'h11, 2'd1, 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 8'h00, 2'd0, 0, 0, 0, 0);
        @(negedge adc_clk);
        rst_n = 1'b1;
        drive(0, 1, 0);
        drive(0, 1, 0);
        check_all("post_rst", 0, 8'h00, 2'd0, 0, 0, 0, 0);
        set_frame(8'h5A, 8'h4B, 8'h3C, 8'h2D);
        drive(1, 1, 0);
        check_all("reload", 1, 8'h5A, 2'd3, 1, 0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        check_all("reload.idle", 0, 8'h00, 2'd0, 0, 0, 0, 0);

        // Random traffic against the queue model.
        model_q.delete();
        model_ov = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic l, r, c, ev;
            logic [7:0] ed;
            logic [1:0] ei;
            for (int k = 0; k < SAMPLES; k++) frame_in[k] = 8'($urandom);
            l = ($urandom_range(0, 99) < 25);
            r = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 99) < 8);
            model_step(l, r, c);
            drive(l, r, c);
            ev = (model_q.size() > 0);
            ed = ev ? model_q[0].data : 8'h00;
            ei = ev ? 2'(model_q[0].idx) : 2'd0;
            check_all($sformatf("rnd%0d", n), ev, ed, ei,
                      ev && (ei == 2'd3), ev && (ei == 2'd0), ev, model_ov);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
